// File: rtl/bit_serial_adder_pkg.sv
// bit_serial_adder_pkg
//   Shared types and helpers for the bit-serial adder slice.
//   - state_e : controller states (IDLE, RUN, DONE)
//   - cnt_w   : width of the bit counter needed to count WIDTH bit steps
package bit_serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // The counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/bit_serial_adder_full_adder.sv
// full_adder
//   1-bit full adder cell that also owns the running carry flop of the
//   bit-serial datapath.
//   Ports:
//     clk_i          in  1  clock, carry flop updates on rising edge
//     reset_n_i      in  1  asynchronous active-low reset, clears the carry
//     a_i, b_i       in  1  current operand bit pair
//     load_i         in  1  load a fresh carry-in (start of an operation)
//     load_carry_i   in  1  carry-in value to load
//     step_i         in  1  advance one bit: carry flop takes the carry-out
//     sum_o          out 1  sum bit of a_i + b_i + stored carry
//     carry_o        out 1  carry-out of a_i + b_i + stored carry
module full_adder (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic a_i,
  input  logic b_i,
  input  logic load_i,
  input  logic load_carry_i,
  input  logic step_i,
  output logic sum_o,
  output logic carry_o
);

  logic carry_q;

  // Combinational full-adder function on the current bit pair and the
  // stored carry.
  always_comb begin
    sum_o   = a_i ^ b_i ^ carry_q;
    carry_o = (a_i & b_i) | (carry_q & (a_i ^ b_i));
  end

  // Carry flop: seeded with the carry-in when an operation is accepted,
  // then follows the cell's carry-out for every processed bit.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      carry_q <= 1'b0;
    end else if (load_i) begin
      carry_q <= load_carry_i;
    end else if (step_i) begin
      carry_q <= carry_o;
    end
  end

endmodule

// File: rtl/bit_serial_adder.sv
// bit_serial_adder
//   Bit-serial WIDTH-bit adder. Operands are accepted over a valid/ready
//   handshake, processed LSB first one bit per clock through a single
//   full_adder cell, and the result is returned over a second valid/ready
//   handshake. Trades WIDTH+2 cycles per operation for a 1-bit datapath.
//   Optional feature macro: BIT_SERIAL_ADDER_SUB_EN adds a sub_i port that
//   turns the operation into a - b (cout_o=1 means no borrow).
//   Ports:
//     clk_i        in  1      clock
//     reset_n_i    in  1      asynchronous active-low reset
//     in_valid_i   in  1      operands valid
//     in_ready_o   out 1      block can accept operands (IDLE only)
//     a_i, b_i     in  WIDTH  operands
//     cin_i        in  1      carry-in for add operations
//     sub_i        in  1      (BIT_SERIAL_ADDER_SUB_EN only) subtract select
//     out_valid_o  out 1      result valid (DONE)
//     out_ready_i  in  1      consumer accepts result
//     sum_o        out WIDTH  result sum, holds last value after handshake
//     cout_o       out 1      result carry-out
//     busy_o       out 1      high in RUN and DONE
module bit_serial_adder
  import bit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
`ifdef BIT_SERIAL_ADDER_SUB_EN
  input  logic             sub_i,
`endif
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             busy_o
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [CW-1:0]    cnt_q;

  logic             accept;
  logic             step;
  logic             load_carry;
  logic [WIDTH-1:0] b_load;
  logic             fa_sum;
  logic             fa_carry;

  // Operand conditioning at accept time. Subtraction is a + ~b + 1, so the
  // inverted B operand and a forced carry of 1 replace b_i and cin_i.
  always_comb begin
    accept = (state_q == IDLE) && in_valid_i;
    step   = (state_q == RUN);
`ifdef BIT_SERIAL_ADDER_SUB_EN
    load_carry = sub_i ? 1'b1 : cin_i;
    b_load     = sub_i ? ~b_i : b_i;
`else
    load_carry = cin_i;
    b_load     = b_i;
`endif
  end

  full_adder u_full_adder (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .a_i          (a_sr[0]),
    .b_i          (b_sr[0]),
    .load_i       (accept),
    .load_carry_i (load_carry),
    .step_i       (step),
    .sum_o        (fa_sum),
    .carry_o      (fa_carry)
  );

  // Controller and datapath registers. Outputs are registered so that
  // in_ready_o/out_valid_o/busy_o change only on clock edges, and sum_o /
  // cout_o are captured once on entry to DONE so partial sums never show.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      in_ready_o  <= 1'b1;
      out_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      sum_o       <= '0;
      cout_o      <= 1'b0;
      cnt_q       <= '0;
      a_sr        <= '0;
      b_sr        <= '0;
      sum_sr      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid_i) begin
            a_sr       <= a_i;
            b_sr       <= b_load;
            cnt_q      <= '0;
            state_q    <= RUN;
            in_ready_o <= 1'b0;
            busy_o     <= 1'b1;
          end
        end

        RUN: begin
          sum_sr <= {fa_sum, sum_sr[WIDTH-1:1]};
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          cnt_q  <= cnt_q + CW'(1);
          // The bit processed on this edge is the MSB, so the complete
          // result is the shifted sum plus this edge's carry-out.
          if (cnt_q == LAST_BIT) begin
            state_q     <= DONE;
            out_valid_o <= 1'b1;
            sum_o       <= {fa_sum, sum_sr[WIDTH-1:1]};
            cout_o      <= fa_carry;
          end
        end

        DONE: begin
          if (out_ready_i) begin
            state_q     <= IDLE;
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            busy_o      <= 1'b0;
          end
        end

        default: begin
          state_q     <= IDLE;
          out_valid_o <= 1'b0;
          in_ready_o  <= 1'b1;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule
